// File: rtl/bcd_pkg.sv
// Shared state encoding and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_SUB    = 4'd3;
  localparam int         SAT8        = 255;

endpackage

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble nibble correction: after a right shift, a nibble >= 8 loses 3.
module bcd_nibble_corr
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= CORR_THRESH) ? (nib_i - CORR_SUB) : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, one reverse double-dabble shift per clock.
// Optional 8-bit saturation with ovf flag when BCD2BIN_OVF_EN is defined.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    binary,
  output logic                err,
  output logic                ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_sh, bcd_corr;
  logic [BIN_W-1:0]   bin_q, bin_d, bin_sh;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   binary_q, binary_d, res_val;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d, res_ovf;
  logic [DIGITS-1:0]  digit_bad;

  // {bcd, bin} shifted right as one long register
  assign bcd_sh = bcd_q >> 1;
  assign bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_bad[gi] = (bcd_in[4*gi +: 4] > DIGIT_MAX);

      bcd_nibble_corr u_corr (
        .nib_i (bcd_sh[4*gi +: 4]),
        .nib_o (bcd_corr[4*gi +: 4])
      );
    end
  endgenerate

  always_comb begin
    res_val = bin_sh;
    res_ovf = 1'b0;
`ifdef BCD2BIN_OVF_EN
    if (bin_sh > BIN_W'(SAT8)) begin
      res_val = BIN_W'(SAT8);
      res_ovf = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (|digit_bad) begin
            state_d  = DONE;
            binary_d = '0;
            err_d    = 1'b1;
            ovf_d    = 1'b0;
          end else begin
            state_d = SHIFT;
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_corr;
        bin_d = bin_sh;
        cnt_d = cnt_q + 1'b1;
        // Final shift lands the result directly in the output register
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          binary_d = res_val;
          err_d    = 1'b0;
          ovf_d    = res_ovf;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign binary = binary_q;
  assign err    = err_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: decimal-arithmetic reference model plus directed vectors.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;
`ifdef BCD2BIN_OVF_EN
  localparam int EXP256_BIN = 255;
  localparam int EXP256_OVF = 1;
`else
  localparam int EXP256_BIN = 256;
  localparam int EXP256_OVF = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [11:0]      bcd_in;
  logic             busy, done, err, ovf;
  logic [BIN_W-1:0] binary;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bcd_in (bcd_in),
    .busy   (busy),
    .done   (done),
    .binary (binary),
    .err    (err),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: decimal value of the captured digits, delivered after a fixed latency
  int m_left;
  bit m_done, m_err, m_ovf, m_was_busy;
  int m_bin, p_bin, p_ovf;
  int d_u, d_t, d_h;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_bin = 0; m_err = 0; m_ovf = 0;
    end else begin
      m_was_busy = (m_left > 0) || m_done;
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_bin = p_bin; m_err = 0; m_ovf = p_ovf[0];
        end
      end else if (!m_was_busy && start) begin
        d_u = int'(bcd_in[3:0]); d_t = int'(bcd_in[7:4]); d_h = int'(bcd_in[11:8]);
        if (d_u > 9 || d_t > 9 || d_h > 9) begin
          m_done = 1; m_bin = 0; m_err = 1; m_ovf = 0;
        end else begin
          p_bin = 100 * d_h + 10 * d_t + d_u;
          p_ovf = 0;
`ifdef BCD2BIN_OVF_EN
          if (p_bin > 255) begin p_bin = 255; p_ovf = 1; end
`endif
          m_left = BIN_W;
        end
      end
    end
  end

  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      checks++;
      if (busy !== ((m_left > 0) || m_done) || done !== m_done || int'(binary) != m_bin
          || err !== m_err || ovf !== m_ovf) begin
        failures++;
        $display("FAIL model cyc=%0d got busy=%0b done=%0b bin=%0d err=%0b ovf=%0b want busy=%0b done=%0b bin=%0d err=%0b ovf=%0b",
                 cyc, busy, done, binary, err, ovf, (m_left > 0) || m_done, m_done, m_bin, m_err, m_ovf);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp_v);
    end
  endtask

  task automatic do_req(input logic [11:0] v, input int exp_b, input int exp_e,
                        input int exp_o, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    start = 1'b1; bcd_in = v;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_bin"}, int'(binary), exp_b);
    chk({nm, "_err"}, int'(err), exp_e);
    chk({nm, "_ovf"}, int'(ovf), exp_o);
    if (exp_e == 0) chk({nm, "_bcdreg_zero"}, int'(dut.bcd_q), 0);
    $display("req %s bcd=%h bin=%0d err=%0b ovf=%0b lat=%0d", nm, v, binary, err, ovf, lat);
  endtask

  initial begin
    int lat, ndone;
    rst = 1'b1; start = 1'b0; bcd_in = 12'h000;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bin", int'(binary), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    do_req(12'h999, 999, 0, 0, 11, "h999");
    @(negedge clk);
    chk("h999_busy_after", int'(busy), 0);
    do_req(12'h128, 128, 0, 0, 11, "h128");
    do_req(12'h000, 0, 0, 0, 11, "h000");
    do_req(12'h01A, 0, 1, 0, 1, "h01A");
    do_req(12'h042, 42, 0, 0, 11, "h042");
    do_req(12'hA00, 0, 1, 0, 1, "hA00");
    do_req(12'h256, EXP256_BIN, 0, EXP256_OVF, 11, "h256");
    do_req(12'h255, 255, 0, 0, 11, "h255");

    // start held high through the conversion, bcd_in changed after capture
    @(negedge clk);
    start = 1'b1; bcd_in = 12'h314;
    @(negedge clk);
    bcd_in = 12'h999;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("held_lat", lat, 11);
    chk("held_bin", int'(binary), 314);
    $display("req held bcd=314 bin=%0d lat=%0d", binary, lat);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("held_extra_done", ndone, 0);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk);
    start = 1'b1; bcd_in = 12'h777;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bin", int'(binary), 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    $display("req abort bcd=777 busy=%0b bin=%0d dones=%0d", busy, binary, ndone);

    do_req(12'h007, 7, 0, 0, 11, "h007");

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
